// File: rtl/clks.sv
// -----------------------------------------------------------------------------
// Module: clks
//
// Purpose
//   Clock divider for the multi-rate datapath. It derives three divided,
//   phase-aligned clocks from the master clock:
//     clk40 = clk/2, clk20 = clk/4, clk10 = clk/8.
//   All three come from one 3-bit up-counter. Each output is a counter flop
//   driven straight to its port with no combinational gating, so the edges
//   stay clean and mutually aligned.
//
// Ports
//   clk     in   master clock; all state changes on its rising edge
//   rst     in   asynchronous reset, active low (0 = reset asserted)
//   enb     in   count enable; 1 = dividers run, 0 = dividers freeze
//   clk10   out  clk/8, 50 % duty (cnt[2])
//   clk20   out  clk/4, 50 % duty (cnt[1])
//   clk40   out  clk/2, 50 % duty (cnt[0])
//   locked  out  present only when CLKS_LOCK_EN is defined; rises on the first
//                counter wrap 7 -> 0 after reset and stays high until reset
//
// Configuration
//   CLKS_LOCK_EN  define this macro to add the `locked` output and its flop.
//                 The default build (macro undefined) has neither.
// -----------------------------------------------------------------------------
module clks (
  input  logic clk,
  input  logic rst,
  input  logic enb,
  output logic clk10,
  output logic clk20,
  output logic clk40
`ifdef CLKS_LOCK_EN
  ,
  output logic locked
`endif
);

  logic [2:0] cnt_r;
  logic [2:0] cnt_next_s;

  // Next counter value: advance when enabled, otherwise freeze the phase.
  always_comb begin
    cnt_next_s = cnt_r;
    if (enb) begin
      cnt_next_s = cnt_r + 3'd1;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Divider counter. Asynchronous reset forces every divided clock low at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 3'b000;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  // Outputs come straight from the counter flops, so the edges stay glitch-free.
  assign clk40 = cnt_r[0];
  assign clk20 = cnt_r[1];
  assign clk10 = cnt_r[2];

`ifdef CLKS_LOCK_EN
  logic locked_r;
  logic locked_next_s;

  // Lock detect. The flag sets on the enabled edge that wraps the counter
  // 7 -> 0, which completes the first full clk10 period. It is sticky until reset.
  always_comb begin
    locked_next_s = locked_r;
    if (enb && (cnt_r == 3'b111)) begin
      locked_next_s = 1'b1;
    end else begin
      locked_next_s = locked_r;
    end
  end

  // Lock flag register. Only reset clears it; enb == 0 does not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked_r <= 1'b0;
    end else begin
      locked_r <= locked_next_s;
    end
  end

  assign locked = locked_r;
`endif

endmodule

// File: tb/tb_clks.sv
// -----------------------------------------------------------------------------
// Testbench for clks. Table-driven directed vectors {enb, expected counter,
// expected lock} are applied one clock edge at a time and checked 1 ns after
// the edge. Hand-written sequences then cover the reset-hold period and an
// asynchronous reset asserted in the middle of operation.
// -----------------------------------------------------------------------------
module tb_clks;

  logic clk;
  logic rst;
  logic enb;
  logic clk10;
  logic clk20;
  logic clk40;
`ifdef CLKS_LOCK_EN
  logic locked;
`endif

  int checks;
  int errors;

  typedef struct {
    logic       enb;
    logic [2:0] exp_cnt;   // expected {clk10, clk20, clk40} after the edge
    logic       exp_lock;  // expected locked after the edge
  } vec_t;

  vec_t vecs [21];

  clks dut (
    .clk   (clk),
    .rst   (rst),
    .enb   (enb),
    .clk10 (clk10),
    .clk20 (clk20),
    .clk40 (clk40)
`ifdef CLKS_LOCK_EN
    ,
    .locked(locked)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_outs(input string name, input logic [2:0] exp);
    logic [2:0] act;
    act = {clk10, clk20, clk40};
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: {clk10,clk20,clk40} got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_lock(input string name, input logic exp);
`ifdef CLKS_LOCK_EN
    checks = checks + 1;
    if (locked !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: locked got %b expected %b at %0t", name, locked, exp, $time);
    end
`endif
  endtask

  // Wait for a rising edge, then settle 1 ns before anything is sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Vectors start from cnt = 0 just after reset release. Each row gives the
    // enb value driven before the edge and the counter value expected after it.
    vecs[0]  = '{1'b1, 3'd1, 1'b0};
    vecs[1]  = '{1'b1, 3'd2, 1'b0};
    vecs[2]  = '{1'b1, 3'd3, 1'b0};
    vecs[3]  = '{1'b1, 3'd4, 1'b0};
    vecs[4]  = '{1'b1, 3'd5, 1'b0};
    vecs[5]  = '{1'b1, 3'd6, 1'b0};
    vecs[6]  = '{1'b1, 3'd7, 1'b0};
    vecs[7]  = '{1'b1, 3'd0, 1'b1};  // first wrap: lock sets
    vecs[8]  = '{1'b1, 3'd1, 1'b1};
    vecs[9]  = '{1'b1, 3'd2, 1'b1};
    vecs[10] = '{1'b1, 3'd3, 1'b1};
    vecs[11] = '{1'b1, 3'd4, 1'b1};
    vecs[12] = '{1'b1, 3'd5, 1'b1};
    vecs[13] = '{1'b0, 3'd5, 1'b1};  // freeze at 101 for 3 cycles
    vecs[14] = '{1'b0, 3'd5, 1'b1};
    vecs[15] = '{1'b0, 3'd5, 1'b1};
    vecs[16] = '{1'b1, 3'd6, 1'b1};  // resume, no phase reset
    vecs[17] = '{1'b1, 3'd7, 1'b1};
    vecs[18] = '{1'b1, 3'd0, 1'b1};
    vecs[19] = '{1'b0, 3'd0, 1'b1};  // freeze at 0, lock stays set
    vecs[20] = '{1'b1, 3'd1, 1'b1};

    // Reset held for 40 ns with enb high: outputs must stay low.
    rst = 1'b0;
    enb = 1'b1;
    #1;
    chk_outs("reset_initial", 3'd0);
    chk_lock("reset_initial_lock", 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_outs("reset_hold", 3'd0);
      chk_lock("reset_hold_lock", 1'b0);
    end

    // Release reset just after a rising edge. clk40 rises on the next edge.
    rst = 1'b1;
    #1;
    chk_outs("release_no_change", 3'd0);

    for (int i = 0; i < 21; i++) begin
      enb = vecs[i].enb;
      step();
      chk_outs($sformatf("vec%0d", i), vecs[i].exp_cnt);
      chk_lock($sformatf("vec%0d_lock", i), vecs[i].exp_lock);
    end

    // Advance from cnt = 1 to cnt = 4 so that clk10 is high.
    enb = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk_outs("pre_async_rst", 3'd4);

    // Assert reset between edges. Outputs must drop before the next edge.
    #2;
    rst = 1'b0;
    #1;
    chk_outs("async_rst_immediate", 3'd0);
    chk_lock("async_rst_lock", 1'b0);
    step();
    chk_outs("async_rst_held", 3'd0);

    // Release with enb low: the counter stays at 0 until enabled.
    enb = 1'b0;
    rst = 1'b1;
    step();
    chk_outs("release_enb_low", 3'd0);
    enb = 1'b1;
    step();
    chk_outs("first_enabled_edge", 3'd1);
    for (int i = 0; i < 6; i++) step();
    chk_outs("pre_wrap_after_rerst", 3'd7);
    chk_lock("pre_wrap_lock", 1'b0);
    step();
    chk_outs("wrap_after_rerst", 3'd0);
    chk_lock("relock", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
